// File: rtl/vnc2_uart_rx.sv
// 8N1 serial receiver feeding the RK keyboard matrix decoder.
// The decoder samples data every clock, so data only ever changes on a good stop bit.
module vnc2_uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e            state_q, state_d;
  logic              rx_meta_q, rx_s_q;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        data_q, data_d;
  logic              valid_q, valid_d;
  logic              frame_err_q, frame_err_d;
  logic              bit_done, half_done;

  // Two-flop synchroniser; both stages idle high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bit_done  = (cnt_q == CntW'(CLKS_PER_BIT - 1));
  assign half_done = (cnt_q == CntW'(HALF_BIT - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (half_done) begin
          cnt_d   = '0;
          idx_d   = '0;
          // A start bit that is high again at its middle was a glitch.
          state_d = rx_s_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (bit_done) begin
          shift_d[idx_q] = rx_s_q;
          cnt_d          = '0;
          if (idx_q == 3'd7) state_d = StStop;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (bit_done) begin
          cnt_d = '0;
          // Leaving at the stop-bit middle lets a back-to-back start edge be caught.
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StBreak;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StBreak: begin
        if (rx_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy      = (state_q != StIdle);
    data      = data_q;
    valid     = valid_q;
    frame_err = frame_err_q;
  end

endmodule

// File: tb/tb_vnc2_uart_rx.sv
// Scoreboard bench for vnc2_uart_rx: the driver queues expected events, a monitor checks them.
`timescale 1ns/1ps
module tb_vnc2_uart_rx;

  localparam int unsigned Cpb     = 16;
  localparam int unsigned Half    = 8;
  localparam int unsigned Latency = 2 + Half + 9 * Cpb;
  localparam real         ClkNs   = 10.0;
  localparam real         BitNs   = ClkNs * Cpb;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  vnc2_uart_rx #(
    .CLKS_PER_BIT (Cpb),
    .HALF_BIT     (Half)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] b;
    bit         chk_lat;
    int         start_cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         passed = 0;
  int         cyc = 0;
  int         both_cnt = 0;
  int         unstable_cnt = 0;
  logic [7:0] model_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: pops one expectation per valid or frame_err pulse.
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    if (reset) begin
      model_data = 8'h00;
    end else begin
      if (valid && frame_err) both_cnt++;
      if (valid || frame_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {30'd0, valid, frame_err}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind", int'(frame_err), int'(e.is_err));
          if (valid) begin
            chk("rx_byte", int'(data), int'(e.b));
            model_data = e.b;
          end else begin
            chk("data_held_on_ferr", int'(data), int'(model_data));
          end
          if (e.chk_lat) begin
            lat = cyc - e.start_cyc - 1;
            chk("latency_in_window",
                int'(lat >= int'(Latency) - 1 && lat <= int'(Latency) + 1), 1);
          end
        end
      end else if (data != model_data) begin
        unstable_cnt++;
      end
    end
  end

  task automatic push(input bit is_err, input logic [7:0] b, input bit chk_lat, input int sc);
    exp_t e;
    e.is_err    = is_err;
    e.b         = b;
    e.chk_lat   = chk_lat;
    e.start_cyc = sc;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b, input real bit_ns, input logic stop_val);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = stop_val;
    #(bit_ns);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    #(BitNs * n);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    #12;
    chk("reset_data", int'(data), 8'h00);
    chk("reset_valid", int'(valid), 0);
    chk("reset_ferr", int'(frame_err), 0);
    chk("reset_busy", int'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    idle_bits(2);

    // 1: single byte at exact baud with latency check
    push(1'b0, 8'h04, 1'b1, cyc);
    send(8'h04, BitNs, 1'b1);
    idle_bits(2);

    // 2: back-to-back frames, no gap
    push(1'b0, 8'h3A, 1'b0, 0);
    push(1'b0, 8'hE1, 1'b0, 0);
    send(8'h3A, BitNs, 1'b1);
    send(8'hE1, BitNs, 1'b1);
    idle_bits(2);

    // 3: short glitch is rejected
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_busy", int'(busy), 0);
    chk("glitch_data", int'(data), 8'hE1);

    // 4: stop bit low, then a 40-bit break
    push(1'b1, 8'h00, 1'b0, 0);
    send(8'h55, BitNs, 1'b0);
    #(BitNs * 40);
    @(negedge clk);
    chk("break_busy", int'(busy), 1);
    chk("break_data", int'(data), 8'hE1);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    chk("break_exit_busy", int'(busy), 0);
    idle_bits(1);
    push(1'b0, 8'h02, 1'b0, 0);
    send(8'h02, BitNs, 1'b1);
    idle_bits(2);
    chk("after_break_data", int'(data), 8'h02);

    // 5: reset in the middle of data bit 4 of an 8'hFF frame
    rx = 1'b0;
    #(BitNs);
    rx = 1'b1;
    #(BitNs * 4 + BitNs / 2);
    reset = 1'b1;
    #2;
    chk("midreset_data", int'(data), 8'h00);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_valid", int'(valid), 0);
    chk("midreset_ferr", int'(frame_err), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle_bits(1);
    push(1'b0, 8'h28, 1'b0, 0);
    send(8'h28, BitNs, 1'b1);
    idle_bits(2);

    // 6: +/-3% baud mismatch
    push(1'b0, 8'hA5, 1'b0, 0);
    send(8'hA5, BitNs * 0.97, 1'b1);
    idle_bits(2);
    push(1'b0, 8'hA5, 1'b0, 0);
    send(8'hA5, BitNs * 1.03, 1'b1);
    idle_bits(2);

    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    chk("no_valid_and_ferr", both_cnt, 0);
    chk("data_stable_between_pulses", unstable_cnt, 0);
    chk("final_data", int'(data), 8'hA5);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/vnc2_uart_rx.md
Name: vnc2_uart_rx

Overview:
- Serial receiver for the byte stream sent by the VNC2 USB-host keyboard bridge.
- Sits directly upstream of the RK keyboard matrix decoder and drives its scancode input.
- Recovers 8N1 frames from the asynchronous rx line and presents the last correctly framed byte as a stable, held level.
- The decoder re-evaluates its input every clock, so data changes only on a good stop bit.

Parameters:
- CLKS_PER_BIT, default 434: clk cycles per bit (50 MHz / 115200). Legal range is 4 or more.
- HALF_BIT, default CLKS_PER_BIT/2: cycles from the detected start edge to the start-bit mid-sample.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx  in  1  serial line from VNC2, idle high, asynchronous to clk.
- data  out  8  last good received byte, held until the next good byte.
- valid  out  1  one-cycle pulse; data was updated this cycle.
- frame_err  out  1  one-cycle pulse; stop bit was sampled low.
- busy  out  1  high while a frame is being received (any state other than IDLE).

Behaviour:
- Reset is asynchronous, active-high, clock is clk.
  - Reset values: data=8'h00, valid=0, frame_err=0, busy=0, state=IDLE, counters=0.
  - Both synchroniser flops reset to 1 (idle line).
- Synchroniser: rx passes through 2 flops. rx_s is the second flop. All decisions use rx_s only.
- Bit-time counter cnt counts 0..CLKS_PER_BIT-1. Bit index idx is 0..7.
- IDLE:
  - busy=0.
  - rx_s==0 -> START, cnt=0.
- START:
  - cnt increments each cycle.
  - When cnt==HALF_BIT-1: if rx_s==0 -> DATA, cnt=0, idx=0. If rx_s==1 -> IDLE (glitch rejected, no pulse).
- DATA:
  - When cnt==CLKS_PER_BIT-1: shift[idx]<=rx_s (LSB first), cnt=0.
  - If idx==7 -> STOP, else idx+1.
- STOP:
  - When cnt==CLKS_PER_BIT-1:
    - rx_s==1: data<=shift, valid=1 for exactly that cycle (registered, same edge as the data update), -> IDLE.
    - rx_s==0: frame_err=1 for one cycle, data unchanged, -> BREAK.
- BREAK:
  - Waits for rx_s==1, then -> IDLE.
  - A held-low line (break) yields exactly one frame_err and no further frames until the line returns high.
- Latency: valid rises (2 + HALF_BIT + 9*CLKS_PER_BIT) clk cycles after the first clk edge that samples rx low, with an uncertainty of ±1 cycle from the synchroniser.
- Repeated identical bytes still produce a valid pulse each. data value is unchanged.
- Back-to-back frames: return to IDLE happens at the stop-bit middle, so a start edge arriving half a bit later is caught. There is no minimum inter-frame gap beyond the nominal stop bit.
- Baud tolerance: the design samples at mid-bit and must accept frames with up to ±3% baud mismatch.
- Reset mid-frame aborts immediately. Partial shift contents are discarded and data returns to 8'h00.
  - If rx is still low after reset release, this is treated as a new start bit. This is defined behaviour; any resulting garbage byte is rejected by stop-bit checking or handled by the decoder.
- valid and frame_err are never high in the same cycle.
- busy is high in START, DATA, STOP and BREAK.
- Downstream contract: 8'h02 is the bridge's "all keys released" code and passes through unmodified. The receiver applies no code interpretation.

Test Plan:
1. CLKS_PER_BIT=16. Send 8N1 byte 8'h04 (A) at exact baud.
   - data=8'h04, one valid pulse at 2+8+144 ±1 cycles after the start edge, frame_err never high.
2. Send 8'h3A then 8'hE1 back-to-back, one stop bit, no gap.
   - Two valid pulses, data=8'h3A then 8'hE1.
   - data is stable between the pulses.
3. Drive rx low for 5 cycles, then high (glitch shorter than HALF_BIT=8).
   - No valid, no frame_err, busy returns to 0 and data is unchanged.
4. Send 8'h55 with the stop bit forced low, and hold rx low for 40 bit times.
   - Exactly one frame_err pulse, data keeps its previous value, busy stays 1 until rx goes high.
   - A following good 8'h02 gives data=8'h02.
5. Assert reset at data bit 4 of a frame carrying 8'hFF, then release with rx high.
   - All outputs go to reset values immediately.
   - The next full frame 8'h28 is received correctly.
6. Send 8'hA5 at 3% fast and then 3% slow baud.
   - Both are received as data=8'hA5 with valid and no frame_err.
